reduce_latency_monitor: RTL and testbench
=========================================

Name: reduce_latency_monitor

Overview:
- Parametrised, bindable checker for reduction-style datapaths. Per channel, it computes the expected reduction of an input bus and delays it by a configurable pipeline latency. It then compares the delayed value against the DUT output on every qualified cycle.
- Keeps a sticky error flag, saturating check and error counters, and a first-failure capture (channel and cycle).
- Attached beside the RTL under test via bind; never synthesised into product logic.

Parameters:
- WIDTH, 4: bits per channel input.
- CHANNELS, 2: number of independent checked channels.
- LATENCY, 1: DUT pipeline depth in cycles, 0..15. 0 means a same-cycle compare.
- MODE, 0: reduction function.
  - 0 = OR-reduce AND AND-reduce.
  - 1 = OR-reduce.
  - 2 = AND-reduce.
  - 3 = XOR-reduce.
- CNT_W, 16: width of all counters.
- ASSERT_EN, 1: when 1, each mismatch raises a simulation $error.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- valid  input  1  qualifies in1 as a sample this cycle.
- in1  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- out  input  CHANNELS  DUT result, bit c for channel c.
- check_en  input  1  when low, comparisons are suppressed; the pipeline still advances.
- armed  output  1  high once LATENCY cycles have elapsed since reset.
- err_sticky  output  1  set on first mismatch, held until RESET.
- err_count  output  CNT_W  mismatching compares, saturating.
- check_count  output  CNT_W  performed compares, saturating.
- first_err_chan  output  max(1,$clog2(CHANNELS))  channel of first mismatch.
- first_err_cycle  output  CNT_W  cycle index of first mismatch.

Behaviour:
- Reset values: all outputs 0, all delay-line entries invalid, cycle counter 0. Reset is synchronous: it takes effect at the CLK edge where RESET=1. Asserting RESET mid-operation discards all in-flight samples.
- Expected value: exp[c] = f_MODE(in1[c]), computed combinationally in the sample cycle.
- Delay line: {valid, exp} is pushed every cycle, with valid=0 pushed when valid is low. It emerges exactly LATENCY cycles later.
  - LATENCY=0 bypasses the delay line; the compare uses the current cycle's values.
- Compare condition: delayed valid=1 AND check_en=1 in the compare cycle. Each such cycle increments check_count by exactly 1 (not per channel).
- Mismatch: for any channel c, (out[c] !== exp_d[c]). X or Z on out counts as a mismatch.
  - err_count increments by 1 per mismatching cycle, however many channels fail.
  - err_sticky is set the following edge.
- First-failure capture:
  - Loaded only when err_sticky=0. Frozen thereafter until RESET.
  - On simultaneous channel failures, first_err_chan is the lowest failing index.
  - first_err_cycle is the cycle counter value of the compare cycle.
- Cycle counter: increments every non-reset cycle, counting from 0 at the first cycle after RESET deasserts. Saturates at all-ones.
- armed: counter from 0 reaching LATENCY, then held at 1. It is 1 immediately after reset when LATENCY=0. armed is informational; compares are gated only by the delayed valid bit.
- Saturation: every counter holds at 2^CNT_W-1 and never wraps.
- Output timing: all outputs are registered and update one edge after the compare cycle.

Decomposition:
- monitor_pkg:
  - reduce_mode_e enum (RED_ORAND, RED_OR, RED_AND, RED_XOR).
  - Function reduce_expected(mode, vec).
  - MAX_LATENCY=15 constant.
  - Saturating-increment function.
- Sub-module mon_delay_line: a parametrised LATENCY-deep shift register carrying {valid, CHANNELS-bit data}, with synchronous clear. For LATENCY=0 it is a pure wire.
- The top level holds the counters, comparison and capture logic.

Test Plan:
- MODE=0, LATENCY=1, CHANNELS=2. in1 ch0=4'hF, ch1=4'h3, valid=1. Next cycle out=2'b01 → no error; check_count=1.
- Same config. in1 ch0=4'hF, ch1=4'hF; next cycle out=2'b01 (ch1 wrong) → err_sticky=1, err_count=1, first_err_chan=1, first_err_cycle = compare cycle index.
- LATENCY=3, MODE=3. Reset then valid every cycle with random in1 and a correct model → armed rises at cycle 3; the first compare occurs at cycle 3; check_count equals the valid cycles minus 3; err_count=0.
- Simultaneous failure of ch0 and ch1, then a later ch1-only failure → err_count=2; first_err_chan=0 and first_err_cycle unchanged after the second failure.
- check_en=0 during a known mismatch → check_count and err_count unchanged. out=X with check_en=1 → counted as a mismatch.
- CNT_W=3: force 9 mismatches → err_count saturates at 7. Assert RESET mid-stream with samples in flight → all outputs 0 next cycle, and no compares for LATENCY cycles after.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and helpers for the reduction latency monitor: reduction modes,
// expected-value computation and saturating arithmetic.
package monitor_pkg;

    typedef enum logic [1:0] {
        RED_ORAND = 2'd0,
        RED_OR    = 2'd1,
        RED_AND   = 2'd2,
        RED_XOR   = 2'd3
    } reduce_mode_e;

    localparam int MAX_LATENCY = 15;
    localparam int MAX_W       = 64;

    // Bits outside mask are neutral: forced 0 for OR/XOR and 1 for AND.
    function automatic logic reduce_expected(input reduce_mode_e mode,
                                             input logic [MAX_W-1:0] vec,
                                             input logic [MAX_W-1:0] mask);
        logic red_or;
        logic red_and;
        logic red_xor;
        red_or  = |(vec & mask);
        red_and = &(vec | ~mask);
        red_xor = ^(vec & mask);
        case (mode)
            RED_ORAND: return red_or & red_and;
            RED_OR:    return red_or;
            RED_AND:   return red_and;
            RED_XOR:   return red_xor;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/mon_delay_line.sv
// LATENCY-deep shift register carrying {valid, expected} with synchronous clear;
// degenerates to a wire when LATENCY is 0.
module mon_delay_line #(
    parameter int LATENCY = 1,
    parameter int DW      = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_d
);

    generate
        if (LATENCY == 0) begin : g_wire
            logic w_unused;
            assign w_unused = CLK ^ RESET;
            assign o_d      = i_d;
        end else begin : g_pipe
            logic [DW-1:0] r_stage [LATENCY];

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_d = r_stage[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/reduce_latency_monitor.sv
// Bindable checker: predicts each channel's reduction, delays it by the DUT
// latency and compares against the DUT output, keeping counters and first-failure info.
module reduce_latency_monitor
    import monitor_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int LATENCY   = 1,
    parameter int MODE      = 0,
    parameter int CNT_W     = 16,
    parameter int ASSERT_EN = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      valid,
    input  logic [CHANNELS*WIDTH-1:0] in1,
    input  logic [CHANNELS-1:0]       out,
    input  logic                      check_en,
    output logic                      armed,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          check_count,
    output logic [CH_W-1:0]           first_err_chan,
    output logic [CNT_W-1:0]          first_err_cycle
);

    localparam reduce_mode_e     RED_MODE = reduce_mode_e'(2'(MODE));
    localparam logic [MAX_W-1:0] W_MASK   = ~({MAX_W{1'b1}} << WIDTH);
    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [4:0]       LAT_U    = 5'(LATENCY);

    logic [CHANNELS-1:0] w_exp;
    logic [CHANNELS:0]   w_dl_out;
    logic                w_dv;
    logic [CHANNELS-1:0] w_de;
    logic                w_do_cmp;
    logic [CHANNELS-1:0] w_mis;
    logic                w_any;
    logic [CH_W-1:0]     w_first_chan;

    logic [CNT_W-1:0]    r_cycle;
    logic [4:0]          r_arm_cnt;
    logic                r_armed;
    logic                r_sticky;
    logic [CNT_W-1:0]    r_err;
    logic [CNT_W-1:0]    r_chk;
    logic [CH_W-1:0]     r_fchan;
    logic [CNT_W-1:0]    r_fcyc;

    always_comb begin
        w_exp = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_exp[c] = reduce_expected(RED_MODE, MAX_W'(in1[c*WIDTH +: WIDTH]), W_MASK);
        end
    end

    mon_delay_line #(
        .LATENCY (LATENCY),
        .DW      (CHANNELS + 1)
    ) u_delay (
        .CLK   (CLK),
        .RESET (RESET),
        .i_d   ({valid, w_exp}),
        .o_d   (w_dl_out)
    );

    assign w_dv     = w_dl_out[CHANNELS];
    assign w_de     = w_dl_out[CHANNELS-1:0];
    assign w_do_cmp = w_dv & check_en;

    // Case inequality so that X/Z on the DUT output is treated as a failure.
    always_comb begin
        w_mis = '0;
        for (int c = 0; c < CHANNELS; c++) w_mis[c] = (out[c] !== w_de[c]);
    end

    assign w_any = |w_mis;

    always_comb begin
        w_first_chan = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_mis[c]) w_first_chan = CH_W'(c);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cycle   <= '0;
            r_arm_cnt <= '0;
            r_armed   <= 1'(LATENCY == 0);
            r_sticky  <= 1'b0;
            r_err     <= '0;
            r_chk     <= '0;
            r_fchan   <= '0;
            r_fcyc    <= '0;
        end else begin
            r_cycle <= CNT_W'(sat_inc(32'(r_cycle), CNT_MAX));
            if (r_arm_cnt < LAT_U) r_arm_cnt <= r_arm_cnt + 5'd1;
            r_armed <= r_armed | (r_arm_cnt + 5'd1 >= LAT_U);
            if (w_do_cmp) begin
                r_chk <= CNT_W'(sat_inc(32'(r_chk), CNT_MAX));
                if (w_any) begin
                    r_err    <= CNT_W'(sat_inc(32'(r_err), CNT_MAX));
                    r_sticky <= 1'b1;
                    if (!r_sticky) begin
                        r_fchan <= w_first_chan;
                        r_fcyc  <= r_cycle;
                    end
                end
            end
        end
    end

    assign armed           = r_armed;
    assign err_sticky      = r_sticky;
    assign err_count       = r_err;
    assign check_count     = r_chk;
    assign first_err_chan  = r_fchan;
    assign first_err_cycle = r_fcyc;

    generate
        if (ASSERT_EN != 0) begin : g_assert
            always_ff @(posedge CLK) begin
                if (!RESET && w_do_cmp) begin
                    assert (!w_any)
                    else $error("reduce_latency_monitor: exp=%b out=%b cycle=%0d", w_de, out, r_cycle);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reduce_latency_monitor.sv
// Self-checking bench: three monitor configurations driven with directed and
// random stimulus, checked against a time-indexed behavioural model.
module tb_reduce_latency_monitor;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [NI];
    logic       vld  [NI];
    logic       cen  [NI];
    logic [7:0] in1  [NI];
    logic [1:0] outv [NI];

    logic        armed  [NI];
    logic        sticky [NI];
    logic [0:0]  fch    [NI];
    logic [15:0] ec     [2];
    logic [15:0] cc     [2];
    logic [15:0] fcy    [2];
    logic [2:0]  ec_c, cc_c, fcy_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: MODE0 LAT1; instance 1: MODE3 LAT3; instance 2: MODE0 LAT2 CNT_W=3
    reduce_latency_monitor #(.WIDTH(4), .CHANNELS(2), .LATENCY(1), .MODE(0), .CNT_W(16), .ASSERT_EN(0)) dut_a (
        .CLK(clk), .RESET(rst[0]), .valid(vld[0]), .in1(in1[0]), .out(outv[0]), .check_en(cen[0]),
        .armed(armed[0]), .err_sticky(sticky[0]), .err_count(ec[0]), .check_count(cc[0]),
        .first_err_chan(fch[0]), .first_err_cycle(fcy[0]));

    reduce_latency_monitor #(.WIDTH(4), .CHANNELS(2), .LATENCY(3), .MODE(3), .CNT_W(16), .ASSERT_EN(0)) dut_b (
        .CLK(clk), .RESET(rst[1]), .valid(vld[1]), .in1(in1[1]), .out(outv[1]), .check_en(cen[1]),
        .armed(armed[1]), .err_sticky(sticky[1]), .err_count(ec[1]), .check_count(cc[1]),
        .first_err_chan(fch[1]), .first_err_cycle(fcy[1]));

    reduce_latency_monitor #(.WIDTH(4), .CHANNELS(2), .LATENCY(2), .MODE(0), .CNT_W(3), .ASSERT_EN(0)) dut_c (
        .CLK(clk), .RESET(rst[2]), .valid(vld[2]), .in1(in1[2]), .out(outv[2]), .check_en(cen[2]),
        .armed(armed[2]), .err_sticky(sticky[2]), .err_count(ec_c), .check_count(cc_c),
        .first_err_chan(fch[2]), .first_err_cycle(fcy_c));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction
    function automatic int mode_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction
    function automatic int cw_of(input int k);
        return (k == 2) ? 3 : 16;
    endfunction

    // Reference reduction written from the mode definitions.
    function automatic logic red(input int mode, input logic [3:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) if (v[i]) ones++;
        case (mode)
            0:       return (ones > 0) && (ones == 4);
            1:       return ones > 0;
            2:       return ones == 4;
            default: return (ones % 2) == 1;
        endcase
    endfunction

    function automatic logic [1:0] exp_of(input int k, input logic [7:0] d);
        return {red(mode_of(k), d[7:4]), red(mode_of(k), d[3:0])};
    endfunction

    // Model: samples indexed by cycle-since-reset; compare cycle t looks at t-LATENCY.
    int         m_n    [NI];
    int         m_cyc  [NI];
    int         m_chk  [NI];
    int         m_err  [NI];
    int         m_fch  [NI];
    int         m_fcyc [NI];
    bit         m_stk  [NI];
    bit         m_arm  [NI];
    bit         hv [NI][4096];
    logic [1:0] he [NI][4096];

    task automatic model_update(input int k);
        int t, lat, mx, first;
        bit dv, anyf;
        logic [1:0] de;
        lat = lat_of(k);
        mx  = (1 << cw_of(k)) - 1;
        if (rst[k]) begin
            m_n[k] = 0; m_cyc[k] = 0; m_chk[k] = 0; m_err[k] = 0;
            m_fch[k] = 0; m_fcyc[k] = 0; m_stk[k] = 0; m_arm[k] = (lat == 0);
        end else begin
            t = m_n[k];
            if (t < 4096) begin
                hv[k][t] = vld[k];
                he[k][t] = exp_of(k, in1[k]);
            end
            dv = 0; de = 2'b00;
            if (t >= lat && t - lat < 4096) begin
                dv = hv[k][t-lat];
                de = he[k][t-lat];
            end
            if (dv && cen[k] === 1'b1) begin
                anyf = 0; first = 0;
                for (int c = 0; c < 2; c++) begin
                    if (outv[k][c] !== de[c]) begin
                        if (!anyf) first = c;
                        anyf = 1;
                    end
                end
                if (m_chk[k] < mx) m_chk[k]++;
                if (anyf) begin
                    if (m_err[k] < mx) m_err[k]++;
                    if (!m_stk[k]) begin
                        m_fch[k]  = first;
                        m_fcyc[k] = m_cyc[k];
                    end
                    m_stk[k] = 1;
                end
            end
            if (m_cyc[k] < mx) m_cyc[k]++;
            if (t + 1 >= lat) m_arm[k] = 1;
            m_n[k] = t + 1;
        end
    endtask

    function automatic logic [50:0] dut_snap(input int k);
        case (k)
            0:       return {armed[0], sticky[0], fch[0], ec[0], cc[0], fcy[0]};
            1:       return {armed[1], sticky[1], fch[1], ec[1], cc[1], fcy[1]};
            default: return {armed[2], sticky[2], fch[2], 13'd0, ec_c, 13'd0, cc_c, 13'd0, fcy_c};
        endcase
    endfunction

    function automatic logic [50:0] mdl_snap(input int k);
        return {m_arm[k], m_stk[k], 1'(m_fch[k]), 16'(m_err[k]), 16'(m_chk[k]), 16'(m_fcyc[k])};
    endfunction

    function automatic logic [1:0] correct_out(input int k);
        int t;
        t = m_n[k] - lat_of(k);
        return (t >= 0 && t < 4096) ? he[k][t] : 2'b00;
    endfunction

    task automatic step();
        for (int k = 0; k < NI; k++) model_update(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        rst[k] = 0; vld[k] = 0; cen[k] = 1; in1[k] = 8'h00; outv[k] = 2'b00;
    endtask

    task automatic reset_one(input int k);
        idle(k);
        rst[k] = 1;
        step();
        rst[k] = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin idle(k); rst[k] = 1; end
        step();
        for (int k = 0; k < NI; k++) rst[k] = 0;
        for (int k = 0; k < NI; k++) begin
            n_cmp++;
            if (dut_snap(k) !== mdl_snap(k)) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got %h want %h", k, dut_snap(k), mdl_snap(k));
            end
        end
        n_cmp++;
        if ({sticky[0], ec[0], cc[0], fcy[0], armed[0]} !== 50'd0) begin
            n_bad++;
            $display("FAIL reset_zero: got %h want 0", {sticky[0], ec[0], cc[0], fcy[0], armed[0]});
        end
    endtask

    task automatic test_basic();
        reset_one(0);
        vld[0] = 1; in1[0] = 8'h3F;
        step();
        vld[0] = 0; outv[0] = 2'b01;
        step();
        n_cmp++;
        if (cc[0] !== 16'd1 || ec[0] !== 16'd0 || sticky[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pass: got chk=%0d err=%0d stk=%b want 1 0 0", cc[0], ec[0], sticky[0]);
        end
    endtask

    task automatic test_first_err();
        vld[0] = 1; in1[0] = 8'hFF;
        step();
        vld[0] = 0; outv[0] = 2'b01;
        step();
        n_cmp++;
        if (sticky[0] !== 1'b1 || ec[0] !== 16'd1 || fch[0] !== 1'b1 || fcy[0] !== 16'd3 || cc[0] !== 16'd2) begin
            n_bad++;
            $display("FAIL first_err: got stk=%b err=%0d ch=%0d cyc=%0d chk=%0d want 1 1 1 3 2",
                     sticky[0], ec[0], fch[0], fcy[0], cc[0]);
        end
    endtask

    task automatic test_simultaneous();
        reset_one(0);
        vld[0] = 1; in1[0] = 8'hFF;
        step();
        vld[0] = 1; in1[0] = 8'hFF; outv[0] = 2'b00;
        step();
        vld[0] = 0; outv[0] = 2'b01;
        step();
        n_cmp++;
        if (ec[0] !== 16'd2 || fch[0] !== 1'b0 || fcy[0] !== 16'd1 || cc[0] !== 16'd2) begin
            n_bad++;
            $display("FAIL simultaneous: got err=%0d ch=%0d cyc=%0d chk=%0d want 2 0 1 2",
                     ec[0], fch[0], fcy[0], cc[0]);
        end
    endtask

    task automatic test_check_en();
        vld[0] = 1; in1[0] = 8'hFF; outv[0] = 2'b11;
        step();
        vld[0] = 0; cen[0] = 0; outv[0] = 2'b00;
        step();
        n_cmp++;
        if (cc[0] !== 16'd2 || ec[0] !== 16'd2) begin
            n_bad++;
            $display("FAIL check_en_off: got chk=%0d err=%0d want 2 2", cc[0], ec[0]);
        end
        vld[0] = 1; in1[0] = 8'hFF; cen[0] = 1; outv[0] = 2'b11;
        step();
        vld[0] = 0; outv[0] = 2'bxx;
        step();
        outv[0] = 2'b00;
        n_cmp++;
        if (dut_snap(0) !== mdl_snap(0)) begin
            n_bad++;
            $display("FAIL out_x: got %h want %h", dut_snap(0), mdl_snap(0));
        end
        n_cmp++;
        if (cc[0] !== 16'd3) begin
            n_bad++;
            $display("FAIL out_x_chk: got %0d want 3", cc[0]);
        end
    endtask

    task automatic test_latency_random();
        reset_one(1);
        for (int i = 0; i < 40; i++) begin
            vld[1] = 1; cen[1] = 1; in1[1] = 8'($urandom);
            outv[1] = correct_out(1);
            step();
            if (i == 1 || i == 2) begin
                n_cmp++;
                if (armed[1] !== (i == 2)) begin
                    n_bad++;
                    $display("FAIL armed_rise i=%0d: got %b want %b", i, armed[1], (i == 2));
                end
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (cc[1] !== 16'(i - 2)) begin
                    n_bad++;
                    $display("FAIL first_compare i=%0d: got %0d want %0d", i, cc[1], i - 2);
                end
            end
        end
        vld[1] = 0;
        n_cmp++;
        if (cc[1] !== 16'd37 || ec[1] !== 16'd0) begin
            n_bad++;
            $display("FAIL latency_count: got chk=%0d err=%0d want 37 0", cc[1], ec[1]);
        end
    endtask

    task automatic test_saturation();
        reset_one(2);
        for (int i = 0; i < 11; i++) begin
            vld[2] = 1; in1[2] = 8'hFF; outv[2] = 2'b00; cen[2] = 1;
            step();
        end
        n_cmp++;
        if (ec_c !== 3'd7 || cc_c !== 3'd7 || fcy_c !== 3'd2 || sticky[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL saturation: got err=%0d chk=%0d cyc=%0d stk=%b want 7 7 2 1",
                     ec_c, cc_c, fcy_c, sticky[2]);
        end
    endtask

    task automatic test_reset_midstream();
        vld[2] = 1; in1[2] = 8'hFF; outv[2] = 2'b00;
        step();
        step();
        rst[2] = 1;
        step();
        rst[2] = 0;
        n_cmp++;
        if ({armed[2], sticky[2], fch[2], ec_c, cc_c, fcy_c} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_midstream: got %h want 0", {armed[2], sticky[2], fch[2], ec_c, cc_c, fcy_c});
        end
        for (int i = 0; i < 3; i++) begin
            vld[2] = 1; outv[2] = 2'b00;
            step();
            n_cmp++;
            if (cc_c !== 3'((i == 2) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL post_reset_quiet i=%0d: got %0d want %0d", i, cc_c, (i == 2) ? 1 : 0);
            end
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int k = 0; k < NI; k++) begin idle(k); rst[k] = 1; end
        step();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NI; k++) begin
                rst[k]  = ($urandom_range(0, 99) == 0);
                vld[k]  = ($urandom_range(0, 3) != 0);
                cen[k]  = ($urandom_range(0, 4) != 0);
                in1[k]  = 8'($urandom);
                outv[k] = ($urandom_range(0, 3) != 0) ? correct_out(k) : 2'($urandom);
            end
            step();
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (dut_snap(k) !== mdl_snap(k)) begin
                    n_bad++;
                    $display("FAIL random[%0d] i=%0d: got %h want %h", k, i, dut_snap(k), mdl_snap(k));
                end
            end
        end
        for (int k = 0; k < NI; k++) idle(k);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            idle(k);
            m_n[k] = 0; m_cyc[k] = 0; m_chk[k] = 0; m_err[k] = 0;
            m_fch[k] = 0; m_fcyc[k] = 0; m_stk[k] = 0; m_arm[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_first_err();
        test_simultaneous();
        test_check_en();
        test_latency_random();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
